axi4lite_slave_regbank: RTL and testbench
=========================================

Name: axi4lite_slave_regbank

Overview:
- Behavioural AXI4-Lite responder (slave) for the testbench library.
- Terminates AXI4-Lite traffic from a master-side transactor or a DUT master port.
- Backs the bus with an internal bank of G_NB_REGS data-width registers and returns OKAY/SLVERR per address decode.
- Exposes a write-event pulse so bench scoreboards can observe committed writes.

Parameters:
- G_AXI4_LITE_ADDR_WIDTH, 32, AXI address width.
- G_AXI4_LITE_DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- G_NB_REGS, 16, number of registers; power of two, at least 2.
- G_BASE_ADDR, 0, byte base address of the register bank; aligned to G_NB_REGS*(DATA_WIDTH/8).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- awvalid  in  1  write address valid
- awaddr  in  ADDR_WIDTH  write address
- awprot  in  3  ignored
- awready  out  1  write address ready
- wvalid  in  1  write data valid
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wready  out  1  write data ready
- bvalid  out  1  write response valid
- bresp  out  2  write response
- bready  in  1  write response ready
- arvalid  in  1  read address valid
- araddr  in  ADDR_WIDTH  read address
- arprot  in  3  ignored
- arready  out  1  read address ready
- rvalid  out  1  read data valid
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rready  in  1  read data ready
- wr_event  out  1  one-cycle pulse when a write commits to the bank
- wr_event_idx  out  log2(G_NB_REGS)  register index of the last committed write

Behaviour:
- Reset, sampled on clk:
  - All registers cleared to 0.
  - awready=1, wready=1, arready=1.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - wr_event=0, wr_event_idx=0.
  - Any transaction in flight is dropped with no response.
- Address decode:
  - offset = addr - G_BASE_ADDR.
  - In range iff offset < G_NB_REGS*(DATA_WIDTH/8).
  - index = offset >> log2(DATA_WIDTH/8); low byte-address bits are ignored.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AW and W channels are captured independently.
  - awready drops the cycle after the AW handshake; wready drops the cycle after the W handshake. Each stays low until the response completes.
  - AW and W may complete in the same cycle or in either order.
- Write commit:
  - Occurs on the edge after the later of the two handshakes.
  - In range: for each byte i with wstrb[i]=1, reg[index] byte i takes wdata byte i; other bytes are unchanged. Then bresp=2'b00, wr_event=1 for one cycle, wr_event_idx=index.
  - Out of range: no register change, bresp=2'b10 (SLVERR), no wr_event.
  - At the same edge: bvalid=1, state goes to W_RESP.
- W_RESP:
  - bvalid and bresp are held stable until bready=1.
  - On the handshake edge: bvalid=0, awready=1, wready=1, state goes to W_IDLE.
  - Minimum write latency: 1 cycle from the later handshake to bvalid.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE with arready=1: on the AR handshake edge, arready=0, rvalid=1, state goes to R_DATA.
  - rdata = reg[index] with rresp=OKAY; out of range gives rdata=0 with rresp=SLVERR.
  - Read latency: rvalid is high the cycle after the AR handshake.
  - R_DATA: rdata and rresp are held stable until rready=1. On the handshake edge: rvalid=0, arready=1, state goes to R_IDLE.
- Simultaneous read and write:
  - Read and write paths are fully independent.
  - A read sampling a register on the same edge as a write commit to that register returns the pre-write value.
- Outstanding transactions:
  - At most one per direction.
  - No new AW/W/AR is accepted until the previous B/R handshake.
- Backpressure: bready or rready held low indefinitely stalls that channel only; the other direction keeps running.

Optional Feature:
- Macro: AXI4LITE_SLAVE_WAIT_STATES_EN.
- Defined:
  - Adds parameter G_WAIT_CYCLES (default 3) and wait states W_WAIT and R_WAIT, each driven by a down-counter.
  - Write: after the later handshake, wait G_WAIT_CYCLES cycles before the commit and bvalid.
  - Read: after the AR handshake, wait G_WAIT_CYCLES cycles before rvalid. rdata is sampled at the edge rvalid rises.
  - G_WAIT_CYCLES=0 behaves exactly like the undefined case.
  - Reset during a wait clears the counter and the state.
- Undefined: fixed 1-cycle latencies as above; no counters in the RTL.

Test Plan:
- Write: AW and W in the same cycle, addr=0x08, data=0xDEADBEEF, wstrb=0xF, bready=1 → bvalid on the next cycle with bresp=00, wr_event pulse with idx=2. Then read 0x08 → rvalid the cycle after AR, rdata=0xDEADBEEF, rresp=00.
- Strobes: reg 1 = 0x11223344; write 0x04 with data 0xAABBCCDD, wstrb=0x5 → read 0x04 returns 0x11BB33DD.
- Channel ordering: W sent 3 cycles before AW (addr 0x0C, 0x12345678), then AW; bready low for 4 cycles → bvalid held with bresp stable for those 4 cycles, awready/wready stay 0 until the B handshake, read 0x0C returns 0x12345678.
- Out of range (G_NB_REGS=16): write 0x40 → bresp=10, no wr_event, bank unchanged; read 0x40 → rdata=0, rresp=10.
- Same-edge conflict: reg 3 = 0x1; write 0x0C=0x2 commits on the same edge as the AR handshake for 0x0C → rdata=0x1, and a subsequent read returns 0x2.
- Reset mid-transaction: assert rst while rvalid=1 and bvalid=1 → next cycle rvalid=0, bvalid=0, all readies=1; read 0x08 afterwards returns 0. With AXI4LITE_SLAVE_WAIT_STATES_EN and G_WAIT_CYCLES=3, rvalid rises exactly 4 cycles after the AR handshake.

Source files
------------

// File: rtl/axi4lite_slave_regbank.sv
// ---------------------------------------------------------------------------
// axi4lite_slave_regbank
//
// Behavioural AXI4-Lite responder backed by a bank of G_NB_REGS registers,
// each G_AXI4_LITE_DATA_WIDTH bits wide. Writes honour byte strobes and
// return OKAY in range or SLVERR out of range. Reads return the register
// contents with OKAY, or zero with SLVERR when out of range. A one-cycle
// wr_event pulse (with wr_event_idx) marks every write that lands in the bank.
//
// Optional build macro: AXI4LITE_SLAVE_WAIT_STATES_EN
//   When defined, adds parameter G_WAIT_CYCLES and inserts that many extra
//   cycles between the (last) address/data handshake and the response on
//   both the write and the read path. G_WAIT_CYCLES = 0 gives the same
//   timing as the default build.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   awvalid/awaddr/awprot     write address channel in (awprot ignored)
//   awready                   write address ready out
//   wvalid/wdata/wstrb        write data channel in
//   wready                    write data ready out
//   bvalid/bresp, bready      write response channel
//   arvalid/araddr/arprot     read address channel in (arprot ignored)
//   arready                   read address ready out
//   rvalid/rdata/rresp,rready read data channel
//   wr_event, wr_event_idx    committed-write pulse and register index
// ---------------------------------------------------------------------------
module axi4lite_slave_regbank #(
  parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int G_AXI4_LITE_DATA_WIDTH = 32,
  parameter int G_NB_REGS              = 16,
  parameter logic [G_AXI4_LITE_ADDR_WIDTH-1:0] G_BASE_ADDR = '0
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  , parameter int G_WAIT_CYCLES        = 3
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  awvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                            awprot,
  output logic                                  awready,
  input  logic                                  wvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata,
  input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb,
  output logic                                  wready,
  output logic                                  bvalid,
  output logic [1:0]                            bresp,
  input  logic                                  bready,
  input  logic                                  arvalid,
  input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr,
  input  logic [2:0]                            arprot,
  output logic                                  arready,
  output logic                                  rvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                            rresp,
  input  logic                                  rready,
  output logic                                  wr_event,
  output logic [$clog2(G_NB_REGS)-1:0]          wr_event_idx
);

  localparam int ADDR_W = G_AXI4_LITE_ADDR_WIDTH;
  localparam int DATA_W = G_AXI4_LITE_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(G_NB_REGS);
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [ADDR_W-1:0] BANK_BYTES = ADDR_W'(G_NB_REGS * STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  localparam int CNT_W = (G_WAIT_CYCLES < 2) ? 1 : $clog2(G_WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(G_WAIT_CYCLES);
`endif

  typedef enum logic [1:0] {
    W_IDLE,
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
    W_WAIT,
`endif
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
    R_WAIT,
`endif
    R_DATA
  } r_state_t;

  // Addresses below the base wrap to a huge offset, so a single unsigned
  // compare covers both ends of the window.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr - G_BASE_ADDR) < BANK_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - G_BASE_ADDR) >> OFF_W);
  endfunction

  logic [DATA_W-1:0] bank [G_NB_REGS];

  w_state_t          w_state, w_state_next;
  logic              aw_got, w_got;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_take, w_take, w_commit, b_done;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_data;
  logic [STRB_W-1:0] cm_strb;
  logic              cm_hit;
  logic [IDX_W-1:0]  cm_idx;

  r_state_t          r_state, r_state_next;
  logic              ar_take, r_load;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [IDX_W-1:0]  rd_idx;

`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  logic [CNT_W-1:0]  w_cnt, r_cnt;
  logic [ADDR_W-1:0] ar_addr_q;
`endif

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  // Handshake-facing outputs are pure decodes of registered state, so they
  // come straight out of flops and reset to the idle (ready) values.
  assign awready = (w_state == W_IDLE) && !aw_got;
  assign wready  = (w_state == W_IDLE) && !w_got;
  assign bvalid  = (w_state == W_RESP);
  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);

  assign aw_take = awvalid && awready;
  assign w_take  = wvalid && wready;
  assign b_done  = (w_state == W_RESP) && bready;

  // A beat handshaking this very cycle is used directly; otherwise the copy
  // captured on its earlier handshake is used.
  assign cm_addr = aw_take ? awaddr : aw_addr_q;
  assign cm_data = w_take ? wdata : w_data_q;
  assign cm_strb = w_take ? wstrb : w_strb_q;
  assign cm_hit  = addr_in_range(cm_addr);
  assign cm_idx  = addr_index(cm_addr);

  assign ar_take = arvalid && arready;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  assign rd_addr = ar_take ? araddr : ar_addr_q;
`else
  assign rd_addr = araddr;
`endif
  assign rd_hit  = addr_in_range(rd_addr);
  assign rd_idx  = addr_index(rd_addr);

  // Write FSM next state: commit once both AW and W have been seen.
  always_comb begin
    w_state_next = w_state;
    w_commit     = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_take || aw_got) && (w_take || w_got)) begin
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
          if (G_WAIT_CYCLES == 0) begin
            w_commit     = 1'b1;
            w_state_next = W_RESP;
          end else begin
            w_state_next = W_WAIT;
          end
`else
          w_commit     = 1'b1;
          w_state_next = W_RESP;
`endif
        end
      end
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      W_WAIT: begin
        if (w_cnt == CNT_W'(1)) begin
          w_commit     = 1'b1;
          w_state_next = W_RESP;
        end
      end
`endif
      W_RESP: begin
        if (bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write state register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      w_cnt   <= '0;
`endif
    end else begin
      w_state <= w_state_next;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      if (w_state == W_IDLE && w_state_next == W_WAIT) begin
        w_cnt <= CNT_LOAD;
      end else if (w_state == W_WAIT) begin
        w_cnt <= w_cnt - CNT_W'(1);
      end
`endif
    end
  end

  // Write datapath: beat capture, register bank update, response and event.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bresp        <= RESP_OKAY;
      wr_event     <= 1'b0;
      wr_event_idx <= '0;
      for (int i = 0; i < G_NB_REGS; i++) begin
        bank[i] <= '0;
      end
    end else begin
      wr_event <= 1'b0;
      if (aw_take) begin
        aw_got    <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_take) begin
        w_got    <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (b_done) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (w_commit) begin
        if (cm_hit) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (cm_strb[b]) begin
              bank[cm_idx][b*8 +: 8] <= cm_data[b*8 +: 8];
            end
          end
          bresp        <= RESP_OKAY;
          wr_event     <= 1'b1;
          wr_event_idx <= cm_idx;
        end else begin
          bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_next = r_state;
    r_load       = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (ar_take) begin
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
          if (G_WAIT_CYCLES == 0) begin
            r_load       = 1'b1;
            r_state_next = R_DATA;
          end else begin
            r_state_next = R_WAIT;
          end
`else
          r_load       = 1'b1;
          r_state_next = R_DATA;
`endif
        end
      end
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      R_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          r_load       = 1'b1;
          r_state_next = R_DATA;
        end
      end
`endif
      R_DATA: begin
        if (rready) begin
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read state register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= r_state_next;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      if (r_state == R_IDLE && r_state_next == R_WAIT) begin
        r_cnt <= CNT_LOAD;
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
`endif
    end
  end

  // Read datapath. The bank is sampled with its pre-edge contents, so a
  // write committing on the same edge is not visible to this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      ar_addr_q <= '0;
`endif
    end else begin
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      if (ar_take) begin
        ar_addr_q <= araddr;
      end
`endif
      if (r_load) begin
        if (rd_hit) begin
          rdata <= bank[rd_idx];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_slave_regbank
//
// Drives directed and randomized AXI4-Lite traffic into the register bank.
// Drivers push expected responses into queues computed from a plain array
// model of the bank; a negedge monitor pops them when bvalid/rvalid rise and
// compares response, data, write event and latency.
// ---------------------------------------------------------------------------
module tb_axi4lite_slave_regbank;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = 16;
  localparam int SB = DW / 8;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  localparam int WAITS = 3;
`else
  localparam int WAITS = 0;
`endif
  localparam int LAT   = 1 + WAITS;
  localparam int BOUND = 60;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0]    awprot = 3'b000, arprot = 3'b000;
  logic [DW-1:0] wdata = '0;
  logic [SB-1:0] wstrb = '0;
  logic          bready = 1'b1, rready = 1'b1;
  logic          awready, wready, bvalid, arready, rvalid, wr_event;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic [3:0]    wr_event_idx;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4lite_slave_regbank #(
    .G_AXI4_LITE_ADDR_WIDTH(AW),
    .G_AXI4_LITE_DATA_WIDTH(DW),
    .G_NB_REGS(NB),
    .G_BASE_ADDR(32'h0)
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
    , .G_WAIT_CYCLES(WAITS)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .wr_event(wr_event), .wr_event_idx(wr_event_idx)
  );

  // Reference bank plus, per register, the value it held before its latest
  // write and the handshake cycle of that write (for same-edge reads).
  logic [31:0] model_regs [NB];
  logic [31:0] prev_val   [NB];
  int          commit_at  [NB];

  typedef struct {
    logic [1:0] resp;
    logic       ev;
    logic [3:0] idx;
    int         due;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } r_exp_t;

  b_exp_t exp_b [$];
  r_exp_t exp_r [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no handshake within %0d cycles (cycle %0d)", name, BOUND, cyc);
  endtask

  function automatic bit in_bank(input logic [31:0] a);
    return a < 32'(NB * SB);
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    return int'(a) / SB;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      model_regs[i] = '0;
      prev_val[i]   = '0;
      commit_at[i]  = -1;
    end
  endfunction

  function automatic void expect_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s, input int when);
    b_exp_t      e;
    int          r;
    logic [31:0] mask;
    e.due = when + LAT;
    if (in_bank(a)) begin
      r    = reg_of(a);
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      prev_val[r]   = model_regs[r];
      commit_at[r]  = when;
      model_regs[r] = (model_regs[r] & ~mask) | (d & mask);
      e.resp = 2'b00;
      e.ev   = 1'b1;
      e.idx  = 4'(r);
    end else begin
      e.resp = 2'b10;
      e.ev   = 1'b0;
      e.idx  = 4'd0;
    end
    exp_b.push_back(e);
  endfunction

  function automatic void expect_read(input logic [31:0] a, input int when);
    r_exp_t e;
    int     r;
    e.due = when + LAT;
    if (in_bank(a)) begin
      r      = reg_of(a);
      e.data = (commit_at[r] == when) ? prev_val[r] : model_regs[r];
      e.resp = 2'b00;
    end else begin
      e.data = '0;
      e.resp = 2'b10;
    end
    exp_r.push_back(e);
  endfunction

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Channel senders: hs is the cycle count seen just before the handshake edge.
  task automatic send_aw(input logic [31:0] a, output int hs);
    awaddr  = a;
    awvalid = 1'b1;
    hs      = -1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (awready) begin
        hs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (hs < 0) report_timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    hs     = -1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (wready) begin
        hs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (hs < 0) report_timeout("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, output int hs);
    araddr  = a;
    arvalid = 1'b1;
    hs      = -1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (arready) begin
        hs = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (hs < 0) report_timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_stall);
    int aw_hs, w_hs;
    bit seen;
    bready = (b_stall == 0);
    fork
      begin wait_cycles(aw_dly); send_aw(a, aw_hs); end
      begin wait_cycles(w_dly);  send_w(d, s, w_hs); end
    join
    if (aw_hs < 0 || w_hs < 0) begin
      bready = 1'b1;
      return;
    end
    expect_write(a, d, s, (aw_hs > w_hs) ? aw_hs : w_hs);
    repeat (b_stall) begin
      @(negedge clk);
      checkOutput("awready_until_b", 32'(awready), 32'd0);
      checkOutput("wready_until_b", 32'(wready), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (bvalid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) report_timeout("b_handshake");
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_stall,
                          output logic [31:0] got);
    int hs;
    bit seen;
    got    = 'x;
    rready = (r_stall == 0);
    wait_cycles(ar_dly);
    send_ar(a, hs);
    if (hs < 0) begin
      rready = 1'b1;
      return;
    end
    expect_read(a, hs);
    wait_cycles(r_stall);
    rready = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (rvalid) begin
        got  = rdata;
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) report_timeout("r_handshake");
    @(posedge clk); #1;
  endtask

  // One randomized step: a write and a read issued concurrently.
  task automatic applyStimulus();
    logic [31:0] wa, wd, ra, got;
    logic [3:0]  ws;
    int          awd, wdl, bst, ard, rst_stall;
    wa  = 32'($urandom_range(0, 79));
    wd  = $urandom;
    ws  = 4'($urandom_range(0, 15));
    ra  = 32'($urandom_range(0, 79));
    awd = int'($urandom_range(0, 3));
    wdl = int'($urandom_range(0, 3));
    bst = int'($urandom_range(0, 3));
    ard = int'($urandom_range(0, 4));
    rst_stall = int'($urandom_range(0, 3));
    fork
      axi_write(wa, wd, ws, awd, wdl, bst);
      axi_read(ra, ard, rst_stall, got);
    join
  endtask

  // Response monitor.
  logic        prev_b = 1'b0, prev_r = 1'b0;
  logic [1:0]  held_bresp, held_rresp;
  logic [31:0] held_rdata;
  b_exp_t      mb;
  r_exp_t      mr;
  bit          new_b, new_r;

  always @(negedge clk) begin
    if (rst) begin
      prev_b = 1'b0;
      prev_r = 1'b0;
    end else begin
      new_b = bvalid && !prev_b;
      new_r = rvalid && !prev_r;
      if (new_b) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bvalid: bresp 0x%0h with nothing expected (cycle %0d)", bresp, cyc);
        end else begin
          mb = exp_b.pop_front();
          checkOutput("bresp", 32'(bresp), 32'(mb.resp));
          checkOutput("b_latency", 32'(cyc), 32'(mb.due));
          checkOutput("wr_event", 32'(wr_event), 32'(mb.ev));
          if (mb.ev) checkOutput("wr_event_idx", 32'(wr_event_idx), 32'(mb.idx));
        end
        held_bresp = bresp;
      end else if (bvalid) begin
        checkOutput("bresp_hold", 32'(bresp), 32'(held_bresp));
      end
      if (wr_event && !new_b) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_wr_event: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (new_r) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rvalid: rdata 0x%0h with nothing expected (cycle %0d)", rdata, cyc);
        end else begin
          mr = exp_r.pop_front();
          checkOutput("rdata", rdata, mr.data);
          checkOutput("rresp", 32'(rresp), 32'(mr.resp));
          checkOutput("r_latency", 32'(cyc), 32'(mr.due));
        end
        held_rdata = rdata;
        held_rresp = rresp;
      end else if (rvalid) begin
        checkOutput("rdata_hold", rdata, held_rdata);
        checkOutput("rresp_hold", 32'(rresp), 32'(held_rresp));
      end
      prev_b = bvalid;
      prev_r = rvalid;
    end
  end

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_awready"}, 32'(awready), 32'd1);
    checkOutput({tag, "_wready"}, 32'(wready), 32'd1);
    checkOutput({tag, "_arready"}, 32'(arready), 32'd1);
    checkOutput({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    checkOutput({tag, "_wr_event"}, 32'(wr_event), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    int aw_hs, w_hs, ar_hs;
    bit both;

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    checkOutput("reset_bresp", 32'(bresp), 32'd0);
    checkOutput("reset_rresp", 32'(rresp), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_wr_event_idx", 32'(wr_event_idx), 32'd0);
    @(posedge clk); #1;

    $display("[TB] basic write/read");
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h08, 0, 0, got);
    checkOutput("basic_read", got, 32'hDEADBEEF);

    $display("[TB] byte strobes");
    axi_write(32'h04, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'hAABBCCDD, 4'h5, 0, 0, 0);
    axi_read(32'h04, 0, 0, got);
    checkOutput("strobe_merge", got, 32'h11BB33DD);

    $display("[TB] W before AW with B backpressure");
    axi_write(32'h0C, 32'h12345678, 4'hF, 3, 0, 4);
    axi_read(32'h0C, 0, 0, got);
    checkOutput("ordered_read", got, 32'h12345678);

    $display("[TB] out of range");
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0, 0, got);
    checkOutput("oor_read", got, 32'd0);
    axi_read(32'h00, 0, 0, got);
    checkOutput("oor_bank_untouched", got, 32'd0);

    $display("[TB] same-edge read and write");
    axi_write(32'h0C, 32'h1, 4'hF, 0, 0, 0);
    fork
      axi_write(32'h0C, 32'h2, 4'hF, 0, 0, 0);
      axi_read(32'h0C, 0, 0, got);
    join
    checkOutput("same_edge_old_value", got, 32'h1);
    axi_read(32'h0C, 0, 0, got);
    checkOutput("same_edge_new_value", got, 32'h2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) applyStimulus();

    $display("[TB] reset with both responses pending");
    bready = 1'b0;
    rready = 1'b0;
    fork
      send_aw(32'h08, aw_hs);
      send_w(32'hCAFEF00D, 4'hF, w_hs);
      send_ar(32'h04, ar_hs);
    join
    if (aw_hs >= 0 && w_hs >= 0) expect_write(32'h08, 32'hCAFEF00D, 4'hF, (aw_hs > w_hs) ? aw_hs : w_hs);
    if (ar_hs >= 0) expect_read(32'h04, ar_hs);
    both = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (bvalid && rvalid) begin
        both = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!both) report_timeout("both_responses_pending");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    bready = 1'b1;
    rready = 1'b1;
    axi_read(32'h08, 0, 0, got);
    checkOutput("read_after_reset", got, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("pending_b_expectations", 32'(exp_b.size()), 32'd0);
    checkOutput("pending_r_expectations", 32'(exp_r.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
